// File: rtl/i2s_pkg.sv
// i2s_pkg: shared FSM encoding, channel constants and default widths for the I2S receiver.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    localparam int DW_DEF    = 16;
    localparam int CNT_W_DEF = 6;

endpackage

// File: rtl/i2s_rx_sync2.sv
// sync2: two-flop synchroniser for one asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic resetb,
    input  logic d_i,
    output logic q_o
);

    logic s1_q, s2_q;
    logic s1_d, s2_d;

    always_comb begin
        s1_d = d_i;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver, deserialises left/right PCM words into one stereo pair per frame.
// Define I2S_RX_ERR_EN to add err_o, flagging short, unequal or saturated slots.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          sck_i,
    input  logic          ws_i,
    input  logic          sd_i,
    output logic [DW-1:0] left_o,
    output logic [DW-1:0] right_o,
    output logic          valid_o
`ifdef I2S_RX_ERR_EN
    ,
    output logic          err_o
`endif
);

    localparam logic [CNT_W-1:0] DW_C = CNT_W'(DW);

    logic sck_s, ws_s, sd_s;

    sync2 u_sync_sck (.clk(clk), .resetb(resetb), .d_i(sck_i), .q_o(sck_s));
    sync2 u_sync_ws  (.clk(clk), .resetb(resetb), .d_i(ws_i),  .q_o(ws_s));
    sync2 u_sync_sd  (.clk(clk), .resetb(resetb), .d_i(sd_i),  .q_o(sd_s));

    state_t            state_q, state_d;
    logic              sck_prev_q, sck_prev_d;
    logic              rise_q, rise_d;
    logic              ws_r_q, ws_r_d;
    logic              sd_r_q, sd_r_d;
    logic              ws_prev_q, ws_prev_d;
    logic [DW-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     hold_l_q, hold_l_d;
    logic              have_l_q, have_l_d;
    logic [DW-1:0]     left_q, left_d;
    logic [DW-1:0]     right_q, right_d;
    logic              valid_q, valid_d;
    logic              ws_edge;
`ifdef I2S_RX_ERR_EN
    logic [CNT_W-1:0]  len_l_q, len_l_d;
    logic              err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        ws_prev_d  = ws_prev_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        hold_l_d   = hold_l_q;
        have_l_d   = have_l_q;
        left_d     = left_q;
        right_d    = right_q;
        valid_d    = 1'b0;
`ifdef I2S_RX_ERR_EN
        len_l_d    = len_l_q;
        err_d      = 1'b0;
`endif
        // Edge-detect stage: rise, ws and sd are registered together so they stay aligned.
        sck_prev_d = sck_s;
        rise_d     = sck_s & ~sck_prev_q;
        ws_r_d     = ws_s;
        sd_r_d     = sd_s;
        ws_edge    = rise_q && (ws_r_q != ws_prev_q);
        if (rise_q) begin
            ws_prev_d = ws_r_q;
            if (state_q == IDLE) begin
                state_d = ws_edge ? ARM : IDLE;
            end else if (ws_edge) begin
                if (ws_r_q == WS_RIGHT) begin
                    hold_l_d = shift_q;
                    have_l_d = 1'b1;
`ifdef I2S_RX_ERR_EN
                    len_l_d  = cnt_q;
`endif
                end else if (have_l_q) begin
                    left_d  = hold_l_q;
                    right_d = shift_q;
                    valid_d = 1'b1;
`ifdef I2S_RX_ERR_EN
                    err_d   = (len_l_q < DW_C) || (cnt_q < DW_C) || (len_l_q != cnt_q) ||
                              (&len_l_q) || (&cnt_q);
`endif
                end
                shift_d = '0;
                cnt_d   = '0;
                state_d = ARM;
            end else if (state_q == ARM) begin
                shift_d = {sd_r_q, {(DW-1){1'b0}}};
                cnt_d   = CNT_W'(1);
                state_d = DATA;
            end else begin
                for (int i = 0; i < DW; i++) begin
                    if (int'(cnt_q) == DW - 1 - i) shift_d[i] = sd_r_q;
                end
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= IDLE;
            sck_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            ws_r_q     <= 1'b0;
            sd_r_q     <= 1'b0;
            ws_prev_q  <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            hold_l_q   <= '0;
            have_l_q   <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sck_prev_q <= sck_prev_d;
            rise_q     <= rise_d;
            ws_r_q     <= ws_r_d;
            sd_r_q     <= sd_r_d;
            ws_prev_q  <= ws_prev_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            hold_l_q   <= hold_l_d;
            have_l_q   <= have_l_d;
            left_q     <= left_d;
            right_q    <= right_d;
            valid_q    <= valid_d;
        end
    end

`ifdef I2S_RX_ERR_EN
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            len_l_q <= '0;
            err_q   <= 1'b0;
        end else begin
            len_l_q <= len_l_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;
`endif

    assign left_o  = left_q;
    assign right_o = right_q;
    assign valid_o = valid_q;

endmodule
